// File: rtl/sms_pkg.sv
// Shared types and constants for the SMS mapper bus front-end.
package sms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILT,
        ST_CAPT,
        ST_HOLD
    } sms_state_e;

    // Mapper control registers, decoded downstream from wr_addr.
    localparam logic [15:0] SMS_REG_RAM   = 16'hFFFC;
    localparam logic [15:0] SMS_REG_BANK0 = 16'hFFFD;
    localparam logic [15:0] SMS_REG_BANK1 = 16'hFFFE;
    localparam logic [15:0] SMS_REG_BANK2 = 16'hFFFF;

    localparam int DEFAULT_FILT_LEN = 2;
    localparam int FILT_CNT_W       = 3;

endpackage

// File: rtl/sms_strobe_filt.sv
// Synchronizer plus glitch-filter FSM for a group of active-low strobes;
// the group counts as asserted while any member is low.
module sms_strobe_filt
    import sms_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = DEFAULT_FILT_LEN,
    parameter int W           = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] strobe_ni,
    output logic [W-1:0] sync_no,
    output logic         accept_o,
    output logic         busy_o
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    sms_state_e                    state_q, state_d;
    logic [FILT_CNT_W-1:0]         cnt_q, cnt_d;
    logic                          active;

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_ni};
        end
    end

    assign sync_no = sync_q[SYNC_STAGES-1];
    assign active  = ~(&sync_no);

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FILT needs the strobe held through FILT_LEN counts before CAPT; HOLD
    // needs FILT_LEN consecutive released cycles, any reassertion restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_FILT;
                    cnt_d   = FILT_CNT_W'(1);
                end
            end
            ST_FILT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_CNT_W'(FILT_LEN)) begin
                    state_d = ST_CAPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + FILT_CNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (active) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_CNT_W'(FILT_LEN - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + FILT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign accept_o = (state_q == ST_CAPT);
    assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: rtl/sms_bus_sync.sv
// Cartridge-bus front-end: turns async write strobes into one clk50 write event.
// Optional RD_STROBE_EN adds a filtered oe path producing rd_stb.
module sms_bus_sync
    import sms_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = DEFAULT_FILT_LEN,
    parameter int ADDR_W      = 23
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              we_lo,
    input  logic              we_hi,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [1:0]        wr_be,
    output logic              busy,
    output logic              rd_stb
);

    logic [ADDR_W-1:0] addr_smp_q;
    logic [15:0]       data_smp_q;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [1:0]        wr_be_q, wr_be_d;
    logic [1:0]        we_sync_n;
    logic              wr_accept;
    logic              wr_busy;

    sms_strobe_filt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .W          (2)
    ) u_wr_filt (
        .clk_i    (clk50),
        .rst_ni   (rst),
        .strobe_ni({we_hi, we_lo}),
        .sync_no  (we_sync_n),
        .accept_o (wr_accept),
        .busy_o   (wr_busy)
    );

`ifdef RD_STROBE_EN
    logic rd_stb_q, rd_stb_d;
    logic oe_sync_unused;
    logic rd_accept;
    logic rd_busy;

    sms_strobe_filt #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN),
        .W          (1)
    ) u_rd_filt (
        .clk_i    (clk50),
        .rst_ni   (rst),
        .strobe_ni(oe),
        .sync_no  (oe_sync_unused),
        .accept_o (rd_accept),
        .busy_o   (rd_busy)
    );

    assign busy   = wr_busy | rd_busy;
    assign rd_stb = rd_stb_q;
`else
    logic oe_unused;

    assign oe_unused = oe;
    assign busy      = wr_busy;
    assign rd_stb    = 1'b0;
`endif

    // A write accepted in the same cycle as a read takes priority; the read is lost.
    always_comb begin
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_be_d   = wr_be_q;
`ifdef RD_STROBE_EN
        rd_stb_d  = 1'b0;
`endif
        if (wr_accept) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_smp_q;
            wr_data_d = data_smp_q;
            wr_be_d   = ~we_sync_n;
        end
`ifdef RD_STROBE_EN
        else if (rd_accept) begin
            rd_stb_d  = 1'b1;
            wr_addr_d = addr_smp_q;
        end
`endif
    end

    always_ff @(negedge clk50) begin
        if (!rst) begin
            addr_smp_q <= '0;
            data_smp_q <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= 2'b00;
`ifdef RD_STROBE_EN
            rd_stb_q   <= 1'b0;
`endif
        end else begin
            addr_smp_q <= addr;
            data_smp_q <= data;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
`ifdef RD_STROBE_EN
            rd_stb_q   <= rd_stb_d;
`endif
        end
    end

    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_be   = wr_be_q;

endmodule

// File: tb/tb_sms_bus_sync.sv
// Directed bench for sms_bus_sync; drives strobes on posedge, DUT works on negedge.
module tb_sms_bus_sync;

    // wr_stb is first seen on the 6th posedge after the strobe is driven:
    // the next negedge samples it, then SYNC_STAGES+FILT_LEN+1 = 5 edges follow.
    localparam int EXP_STB_STEP = 6;

    logic        clk50;
    logic        rst;
    logic        we_lo;
    logic        we_hi;
    logic        oe;
    logic [22:0] addr;
    logic [15:0] data;
    logic        wr_stb;
    logic [22:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        busy;
    logic        rd_stb;

    int assertCount = 0;
    int failCount   = 0;
    int stepIdx;
    int stbCount;
    int firstStb;
    int rdCount;
    int firstRd;
    int busySeen;

    sms_bus_sync dut (
        .clk50  (clk50),
        .rst    (rst),
        .we_lo  (we_lo),
        .we_hi  (we_hi),
        .oe     (oe),
        .addr   (addr),
        .data   (data),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be  (wr_be),
        .busy   (busy),
        .rd_stb (rd_stb)
    );

    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lo, input logic hi, input logic rdN,
                                 input logic [22:0] a, input logic [15:0] d);
        we_lo = lo;
        we_hi = hi;
        oe    = rdN;
        addr  = a;
        data  = d;
    endtask

    task automatic clearTrack();
        stepIdx  = 0;
        stbCount = 0;
        firstStb = 0;
        rdCount  = 0;
        firstRd  = 0;
        busySeen = 0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk50);
            stepIdx++;
            if (wr_stb === 1'b1) begin
                stbCount++;
                if (firstStb == 0) firstStb = stepIdx;
            end
            if (rd_stb === 1'b1) begin
                rdCount++;
                if (firstRd == 0) firstRd = stepIdx;
            end
            if (busy === 1'b1) busySeen = 1;
        end
    endtask

    initial begin
        clearTrack();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h0, 16'h0);
        runCycles(4);
        checkOutput("reset wr_stb", 32'(wr_stb), 32'h0);
        checkOutput("reset wr_addr", 32'(wr_addr), 32'h0);
        checkOutput("reset wr_data", 32'(wr_data), 32'h0);
        checkOutput("reset wr_be", 32'(wr_be), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset rd_stb", 32'(rd_stb), 32'h0);
        rst = 1'b1;
        runCycles(2);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h00FFFD, 16'h0003);
        runCycles(10);
        checkOutput("lo busy held", 32'(busy), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFD, 16'h0003);
        runCycles(8);
        checkOutput("lo stb count", 32'(stbCount), 32'd1);
        checkOutput("lo stb latency", 32'(firstStb), 32'(EXP_STB_STEP));
        checkOutput("lo wr_addr", 32'(wr_addr), 32'h00FFFD);
        checkOutput("lo wr_data", 32'(wr_data), 32'h0003);
        checkOutput("lo wr_be", 32'(wr_be), 32'h1);
        checkOutput("lo busy idle", 32'(busy), 32'h0);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h000123, 16'hBEEF);
        runCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h000123, 16'hBEEF);
        runCycles(10);
        checkOutput("glitch stb count", 32'(stbCount), 32'd0);
        checkOutput("glitch busy pulse", 32'(busySeen), 32'd1);
        checkOutput("glitch busy idle", 32'(busy), 32'h0);
        checkOutput("glitch addr hold", 32'(wr_addr), 32'h00FFFD);
        checkOutput("glitch data hold", 32'(wr_data), 32'h0003);

        clearTrack();
        applyStimulus(1'b0, 1'b0, 1'b1, 23'h00FFFE, 16'hA55A);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFE, 16'hA55A);
        runCycles(8);
        checkOutput("both stb count", 32'(stbCount), 32'd1);
        checkOutput("both stb latency", 32'(firstStb), 32'(EXP_STB_STEP));
        checkOutput("both wr_be", 32'(wr_be), 32'h3);
        checkOutput("both wr_data", 32'(wr_data), 32'hA55A);
        checkOutput("both wr_addr", 32'(wr_addr), 32'h00FFFE);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h00FFFF, 16'h1234);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 23'h00FFFF, 16'h1234);
        runCycles(9);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFF, 16'h1234);
        runCycles(8);
        checkOutput("merge stb count", 32'(stbCount), 32'd1);
        checkOutput("merge stb latency", 32'(firstStb), 32'(EXP_STB_STEP));
        checkOutput("merge wr_be", 32'(wr_be), 32'h3);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h00FFFC, 16'h0080);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFC, 16'h0080);
        runCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h00FFFC, 16'h0080);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFC, 16'h0080);
        runCycles(8);
        checkOutput("bounce stb count", 32'(stbCount), 32'd1);
        checkOutput("bounce wr_be", 32'(wr_be), 32'h1);
        checkOutput("bounce busy idle", 32'(busy), 32'h0);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b1, 23'h00FFFD, 16'h0005);
        runCycles(10);
        checkOutput("rst pre stb count", 32'(stbCount), 32'd1);
        rst = 1'b0;
        runCycles(2);
        checkOutput("rst busy", 32'(busy), 32'h0);
        checkOutput("rst wr_stb", 32'(wr_stb), 32'h0);
        checkOutput("rst wr_addr", 32'(wr_addr), 32'h0);
        clearTrack();
        rst = 1'b1;
        runCycles(10);
        checkOutput("rst post stb count", 32'(stbCount), 32'd1);
        checkOutput("rst post latency", 32'(firstStb), 32'(EXP_STB_STEP));
        checkOutput("rst post wr_addr", 32'(wr_addr), 32'h00FFFD);
        checkOutput("rst post wr_data", 32'(wr_data), 32'h0005);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFD, 16'h0005);
        runCycles(8);
        checkOutput("rst post busy idle", 32'(busy), 32'h0);

`ifdef RD_STROBE_EN
        clearTrack();
        applyStimulus(1'b1, 1'b1, 1'b0, 23'h004000, 16'h0000);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h004000, 16'h0000);
        runCycles(8);
        checkOutput("rd count", 32'(rdCount), 32'd1);
        checkOutput("rd latency", 32'(firstRd), 32'(EXP_STB_STEP));
        checkOutput("rd no wr_stb", 32'(stbCount), 32'd0);
        checkOutput("rd wr_addr", 32'(wr_addr), 32'h004000);

        clearTrack();
        applyStimulus(1'b0, 1'b1, 1'b0, 23'h00FFFD, 16'h0007);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h00FFFD, 16'h0007);
        runCycles(8);
        checkOutput("rdwr stb count", 32'(stbCount), 32'd1);
        checkOutput("rdwr rd dropped", 32'(rdCount), 32'd0);
        checkOutput("rdwr wr_data", 32'(wr_data), 32'h0007);
`else
        clearTrack();
        applyStimulus(1'b1, 1'b1, 1'b0, 23'h004000, 16'h0000);
        runCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 23'h004000, 16'h0000);
        runCycles(8);
        checkOutput("oe rd count", 32'(rdCount), 32'd0);
        checkOutput("oe no wr_stb", 32'(stbCount), 32'd0);
        checkOutput("oe no busy", 32'(busySeen), 32'd0);
        checkOutput("oe addr hold", 32'(wr_addr), 32'h00FFFD);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
